reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and data-port width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; register count is 2**ADDR_W (32).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports are named clock and reset.
REQ-004 The block SHALL have port clock, input, 1 bit; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; it is synchronous and active-high, and clears all registers.
REQ-006 The block SHALL have port we_in, input, 1 bit; it is the write enable.
REQ-007 The block SHALL have port waddr_in, input, ADDR_W bits; it is the write address.
REQ-008 The block SHALL have port wdata_in, input, DATA_W bits; it is the write data.
REQ-009 The block SHALL have port raddr1_in, input, ADDR_W bits; it is the read port 1 address.
REQ-010 The block SHALL have port raddr2_in, input, ADDR_W bits; it is the read port 2 address.
REQ-011 The block SHALL have port rdata1_out, output, DATA_W bits; it is the read port 1 data.
REQ-012 The block SHALL have port rdata2_out, output, DATA_W bits; it is the read port 2 data.

Function
REQ-013 The block SHALL hold 2**ADDR_W registers of DATA_W bits each.
REQ-014 Writes SHALL occur on the rising clock edge when we_in=1 and reset=0, storing wdata_in into register waddr_in.
REQ-015 Writes to address 0 SHALL be ignored; register 0 SHALL read as all zeros at all times.
REQ-016 Both read ports SHALL be combinational (zero-cycle latency); each output SHALL follow its address and the stored contents without a clock edge.
REQ-017 The two read ports SHALL be fully independent; an identical address on both ports SHALL return identical data.
REQ-018 A write SHALL be visible on the read ports from the rising edge on which it occurs onward; read-during-write behaviour in the same cycle is defined by REQ-023/024.
REQ-019 Registers not addressed by a write SHALL retain their values; with we_in=0, no register SHALL change.
REQ-020 X or undriven read addresses are outside the contract; the block SHALL impose no behaviour on them beyond plain indexing.

Reset
REQ-021 When reset=1 at a rising edge, all registers SHALL become 0 and any concurrent write SHALL be discarded (reset has priority).
REQ-022 Read outputs SHALL therefore be 0 for every address from the edge after reset is sampled onward; reset applied mid-operation SHALL behave identically.

Configuration
REQ-023 With macro REG_FILE_BYPASS_EN defined, a read port whose address equals waddr_in while we_in=1, reset=0 and waddr_in!=0 SHALL return wdata_in combinationally in that same cycle (write-through forwarding).
REQ-024 Without REG_FILE_BYPASS_EN, such a read SHALL return the stored (old) value until the write edge; no forwarding logic SHALL be present.

Structure
REQ-025 A shared package reg_file_pkg SHALL define the default DATA_W and ADDR_W constants, NUM_REGS, the ZERO_REG address constant (0) and a data-word typedef.
REQ-026 One sub-module, reg_file_rd_port (address decode/mux plus the optional bypass compare), SHALL be instantiated once per read port; the storage array and write logic stay in reg_file.

Verification
REQ-027 The bench SHALL drive reset=1 for one edge, then read all 32 addresses on both ports and require 0 for every address.
REQ-028 The bench SHALL write register 5 with 32'hDEADBEEF (we_in=1 for one edge), then set raddr1=5 and raddr2=0, and require rdata1=DEADBEEF and rdata2=00000000.
REQ-029 The bench SHALL write register 0 with 32'hFFFFFFFF, then set raddr1=0 and raddr2=5, and require rdata1=00000000 and rdata2=DEADBEEF.
REQ-030 The bench SHALL write register 31 with 32'h12345678 and register 1 with 32'hA5A5A5A5, then set raddr1=raddr2=31, and require both outputs =12345678 and register 1 unchanged.
REQ-031 The bench SHALL hold we_in=1, waddr=7, wdata=32'hCAFEF00D with raddr1=7 before the edge, and require CAFEF00D pre-edge with REG_FILE_BYPASS_EN, or the old value (0) pre-edge without it, and CAFEF00D post-edge in both builds.
REQ-032 The bench SHALL assert reset and we_in=1 (waddr=5, wdata=32'h11111111) at the same edge, and require register 5 to read 00000000 afterwards.

Source files
------------

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and types for the register file
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;
  localparam int ZERO_REG       = 0;

  typedef logic [DEFAULT_DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - combinational read mux; REG_FILE_BYPASS_EN adds write-through forwarding
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] addr,
`ifdef REG_FILE_BYPASS_EN
  input  logic              fwd_en,
  input  logic [ADDR_W-1:0] fwd_addr,
  input  logic [DATA_W-1:0] fwd_data,
`endif
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = regs[addr];
    // register 0 is hard-wired, independent of whatever its flops hold
    if (addr == ADDR_W'(ZERO_REG)) begin
      rdata = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    else if (fwd_en && (fwd_addr == addr)) begin
      rdata = fwd_data;
    end
`endif
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read/1-write register file, register 0 reads zero
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [ADDR_W-1:0] raddr1_in,
  input  logic [ADDR_W-1:0] raddr2_in,
  output logic [DATA_W-1:0] rdata1_out,
  output logic [DATA_W-1:0] rdata2_out
);

  localparam int NUM = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM];

  always_ff @(posedge clock) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (we_in && (waddr_in != ADDR_W'(ZERO_REG))) begin
      regs[waddr_in] <= wdata_in;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic fwd_en;
  assign fwd_en = we_in && !reset && (waddr_in != ADDR_W'(ZERO_REG));
`endif

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .regs     (regs),
    .addr     (raddr1_in),
`ifdef REG_FILE_BYPASS_EN
    .fwd_en   (fwd_en),
    .fwd_addr (waddr_in),
    .fwd_data (wdata_in),
`endif
    .rdata    (rdata1_out)
  );

  reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .regs     (regs),
    .addr     (raddr2_in),
`ifdef REG_FILE_BYPASS_EN
    .fwd_en   (fwd_en),
    .fwd_addr (waddr_in),
    .fwd_data (wdata_in),
`endif
    .rdata    (rdata2_out)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file (either REG_FILE_BYPASS_EN build)
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clock;
  logic        reset;
  logic        we_in;
  logic [4:0]  waddr_in;
  word_t       wdata_in;
  logic [4:0]  raddr1_in;
  logic [4:0]  raddr2_in;
  word_t       rdata1_out;
  word_t       rdata2_out;

  int tests;
  int fails;

  reg_file dut (
    .clock      (clock),
    .reset      (reset),
    .we_in      (we_in),
    .waddr_in   (waddr_in),
    .wdata_in   (wdata_in),
    .raddr1_in  (raddr1_in),
    .raddr2_in  (raddr2_in),
    .rdata1_out (rdata1_out),
    .rdata2_out (rdata2_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_write(input logic [4:0] a, input word_t d);
    we_in    = 1'b1;
    waddr_in = a;
    wdata_in = d;
    @(posedge clock);
    #1;
    we_in    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      raddr1_in = 5'(i);
      raddr2_in = 5'(NUM_REGS - 1 - i);
      #1;
      tests++;
      if (rdata1_out !== 32'h0) begin
        fails++;
        $display("FAIL reset_rd1 addr=%0d got=%08h exp=00000000", i, rdata1_out);
      end
      tests++;
      if (rdata2_out !== 32'h0) begin
        fails++;
        $display("FAIL reset_rd2 addr=%0d got=%08h exp=00000000", NUM_REGS - 1 - i, rdata2_out);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEADBEEF);
    raddr1_in = 5'd5;
    raddr2_in = 5'd0;
    #1;
    tests++;
    if (rdata1_out !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wr5_rd1 got=%08h exp=DEADBEEF", rdata1_out);
    end
    tests++;
    if (rdata2_out !== 32'h0) begin
      fails++;
      $display("FAIL wr5_rd2_zero got=%08h exp=00000000", rdata2_out);
    end
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'hFFFFFFFF);
    raddr1_in = 5'd0;
    raddr2_in = 5'd5;
    #1;
    tests++;
    if (rdata1_out !== 32'h0) begin
      fails++;
      $display("FAIL zero_reg got=%08h exp=00000000", rdata1_out);
    end
    tests++;
    if (rdata2_out !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL zero_reg_rd2 got=%08h exp=DEADBEEF", rdata2_out);
    end
  endtask

  task automatic test_boundary();
    do_write(5'd31, 32'h12345678);
    do_write(5'd1,  32'hA5A5A5A5);
    raddr1_in = 5'd31;
    raddr2_in = 5'd31;
    #1;
    tests++;
    if (rdata1_out !== 32'h12345678) begin
      fails++;
      $display("FAIL r31_rd1 got=%08h exp=12345678", rdata1_out);
    end
    tests++;
    if (rdata2_out !== 32'h12345678) begin
      fails++;
      $display("FAIL r31_rd2 got=%08h exp=12345678", rdata2_out);
    end
    raddr1_in = 5'd1;
    raddr2_in = 5'd5;
    #1;
    tests++;
    if (rdata1_out !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL r1_hold got=%08h exp=A5A5A5A5", rdata1_out);
    end
    tests++;
    if (rdata2_out !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL r5_hold got=%08h exp=DEADBEEF", rdata2_out);
    end
    raddr1_in = 5'd2;
    #1;
    tests++;
    if (rdata1_out !== 32'h0) begin
      fails++;
      $display("FAIL r2_untouched got=%08h exp=00000000", rdata1_out);
    end
  endtask

  task automatic test_idle_hold();
    we_in     = 1'b0;
    waddr_in  = 5'd31;
    wdata_in  = 32'h0BADF00D;
    repeat (2) @(posedge clock);
    #1;
    raddr1_in = 5'd31;
    #1;
    tests++;
    if (rdata1_out !== 32'h12345678) begin
      fails++;
      $display("FAIL we0_hold got=%08h exp=12345678", rdata1_out);
    end
  endtask

  task automatic test_bypass();
    word_t pre_exp;
`ifdef REG_FILE_BYPASS_EN
    pre_exp = 32'hCAFEF00D;
`else
    pre_exp = 32'h0;
`endif
    raddr1_in = 5'd7;
    raddr2_in = 5'd1;
    we_in     = 1'b1;
    waddr_in  = 5'd7;
    wdata_in  = 32'hCAFEF00D;
    #1;
    tests++;
    if (rdata1_out !== pre_exp) begin
      fails++;
      $display("FAIL bypass_pre got=%08h exp=%08h", rdata1_out, pre_exp);
    end
    tests++;
    if (rdata2_out !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL bypass_other_port got=%08h exp=A5A5A5A5", rdata2_out);
    end
    @(posedge clock);
    #1;
    we_in = 1'b0;
    #1;
    tests++;
    if (rdata1_out !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL bypass_post got=%08h exp=CAFEF00D", rdata1_out);
    end
  endtask

  task automatic test_reset_priority();
    reset    = 1'b1;
    we_in    = 1'b1;
    waddr_in = 5'd5;
    wdata_in = 32'h11111111;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    we_in    = 1'b0;
    raddr1_in = 5'd5;
    raddr2_in = 5'd31;
    #1;
    tests++;
    if (rdata1_out !== 32'h0) begin
      fails++;
      $display("FAIL rst_prio_r5 got=%08h exp=00000000", rdata1_out);
    end
    tests++;
    if (rdata2_out !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_r31 got=%08h exp=00000000", rdata2_out);
    end
    raddr1_in = 5'd7;
    #1;
    tests++;
    if (rdata1_out !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_r7 got=%08h exp=00000000", rdata1_out);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    we_in     = 1'b0;
    waddr_in  = '0;
    wdata_in  = '0;
    raddr1_in = '0;
    raddr2_in = '0;
    @(negedge clock);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_boundary();
    test_idle_hold();
    test_bypass();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
